// File: rtl/if_stage_pkg.sv
// Shared core definitions for the fetch stage: FSM state encoding and the
// native instruction width.
package if_stage_pkg;

    localparam int INSTR_W = 32;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/syn_reg.sv
// Generic enabled register with asynchronous active-high reset to a
// parameterised value.
module syn_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] INITIAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= INITIAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request at a time, one
// instruction buffered towards decode, redirects override everything.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int              XLEN     = INSTR_W,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [1:0]      state
);

    // Handshake rule on every interface: a transfer happens in a cycle where
    // valid and ready are both high; valid never depends on ready.

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] fetch_pc;
    logic            kill;
    logic            req_fire;
    logic            unused_bits;

    assign imem_req_valid = (state == ST_REQ) && !redirect_valid;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_next        = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                                           : pc + XLEN'(4);
    assign unused_bits    = ^redirect_pc[1:0];

    syn_reg #(
        .WIDTH  (XLEN),
        .INITIAL(RESET_PC)
    ) u_pc (
        .clk(clk),
        .rst(rst),
        .en (req_fire || redirect_valid),
        .d  (pc_next),
        .q  (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_REQ;
            kill      <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            fetch_pc  <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        fetch_pc <= pc;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response that races a redirect belongs to the old path.
                    if (imem_rsp_valid) begin
                        if (kill || redirect_valid) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            out_pc    <= fetch_pc;
                            out_instr <= imem_rsp_data;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomised fetch-stage bench: memory and decode models drive the DUT, and a
// reference fetch stream feeds a scoreboard checked by a separate monitor.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        redirect_valid, out_valid, out_ready;
    logic [31:0] redirect_pc, out_pc, out_instr;
    logic [1:0]  dut_state;

    if_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .state(dut_state)
    );

    // wrap-around DUT
    logic        req_valid2, req_ready2, rsp_valid2;
    logic [31:0] addr2, rsp_data2;
    logic        redirect2, out_valid2, out_ready2;
    logic [31:0] redirect_pc2, out_pc2, out_instr2;
    logic [1:0]  state2;

    if_stage #(.XLEN(32), .RESET_PC(RST_PC2)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2),
        .imem_addr(addr2), .imem_rsp_valid(rsp_valid2),
        .imem_rsp_data(rsp_data2), .redirect_valid(redirect2),
        .redirect_pc(redirect_pc2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_pc(out_pc2), .out_instr(out_instr2), .state(state2)
    );

    // scoreboard
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    int          push_cyc = -1;

    // stimulus knobs and directed triggers
    int          p_rdy = 100, p_ordy = 100, p_redir = 0, p_spur = 0;
    int          lat_min = 1, lat_max = 1;
    bit          redir_in_wait = 0, redir_in_req = 0;
    bit          force_addr_en = 0, force_out_en = 0;
    logic [31:0] force_addr, force_out_pc;

    // reference model: next fetch address, outstanding request, memory slot
    logic [31:0] exp_pc = RST_PC;
    bit          model_wait = 0, mem_pending = 0, mem_live = 0;
    int          mem_due = 0;
    logic [31:0] mem_addr, mem_data;
    int          hs_idx = 0, hs2_idx = 0;
    bit          hs2_prev = 0, redir_seen = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: one clock cycle of stimulus plus memory/model bookkeeping
    task automatic step(input bit r);
        bit          rsp_now, redir, rdy, ordy, hs, exp_rv, chk_rq;
        logic [31:0] rpc;
        @(posedge clk);
        #1;
        if (r) begin
            rst = 1'b1;
            redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
            out_ready = 1'b0; rsp_valid2 = 1'b0;
            exp_q.delete();
            model_wait = 0; mem_live = 0; exp_pc = RST_PC;
            hs_idx = 0; hs2_idx = 0; hs2_prev = 0; redir_seen = 0;
            #1;
            check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'h0);
            check(out_pc == 32'h0, "rst_out_pc", out_pc, 32'h0);
            check(out_instr == 32'h0, "rst_out_instr", out_instr, 32'h0);
            check(dut_state == ST_REQ, "rst_state", 32'(dut_state), 32'(ST_REQ));
            check(imem_addr == RST_PC, "rst_pc", imem_addr, RST_PC);
            check(addr2 == RST_PC2, "rst_pc2", addr2, RST_PC2);
            return;
        end
        rst = 1'b0;
        chk_rq = 0;
        rsp_now = mem_pending && (cyc >= mem_due);
        redir = (int'($urandom_range(99)) < p_redir);
        rpc = $urandom;
        if (redir_in_wait && model_wait && mem_live && !rsp_now) begin
            redir = 1; rpc = 32'h0000_0103; redir_in_wait = 0;
            force_addr_en = 1; force_addr = 32'h0000_0100;
            force_out_en = 1; force_out_pc = 32'h0000_0100;
        end
        rdy = (int'($urandom_range(99)) < p_rdy);
        if (mem_pending && !model_wait) rdy = 0;  // stale response still owed
        if (redir_in_req && !model_wait && !mem_pending && exp_q.size() == 0) begin
            redir = 1; rdy = 1; rpc = 32'h0000_2000; redir_in_req = 0; chk_rq = 1;
            force_addr_en = 1; force_addr = 32'h0000_2000;
        end
        ordy = (int'($urandom_range(99)) < p_ordy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        out_ready      = ordy;
        imem_rsp_valid = rsp_now || (!mem_pending && int'($urandom_range(99)) < p_spur);
        imem_rsp_data  = rsp_now ? mem_data : $urandom;
        rsp_valid2 = hs2_prev; rsp_data2 = $urandom;
        #1;
        exp_rv = !model_wait && (exp_q.size() == 0) && !redir;
        check(imem_req_valid == exp_rv, "req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (chk_rq) check(imem_req_valid == 1'b0, "redir_req_suppress", 32'(imem_req_valid), 32'h0);
        hs = imem_req_valid && rdy;
        if (rsp_now) begin
            if (mem_live && !redir) begin
                exp_q.push_back({mem_addr, mem_data});
                push_cyc = cyc;
            end
            mem_pending = 0;
            model_wait = 0;
        end
        if (redir && model_wait) mem_live = 0;
        if (hs) begin
            check(imem_addr == exp_pc, "fetch_addr", imem_addr, exp_pc);
            if (hs_idx < 3 && !redir_seen)
                check(imem_addr == RST_PC + 32'(4 * hs_idx), "seq_addr", imem_addr, RST_PC + 32'(4 * hs_idx));
            if (force_addr_en) begin
                check(imem_addr == force_addr, "redir_target", imem_addr, force_addr);
                force_addr_en = 0;
            end
            hs_idx++;
            mem_pending = 1; mem_live = 1; model_wait = 1;
            mem_addr = exp_pc; mem_data = $urandom;
            mem_due = cyc + int'($urandom_range(lat_max, lat_min));
        end
        if (redir) begin
            exp_pc = {rpc[31:2], 2'b00};
            redir_seen = 1;
        end else if (hs) begin
            exp_pc = exp_pc + 32'd4;
        end
        if (req_valid2) begin
            if (hs2_idx < 3)
                check(addr2 == RST_PC2 + 32'(4 * hs2_idx), "wrap_addr", addr2, RST_PC2 + 32'(4 * hs2_idx));
            hs2_idx++;
        end
        hs2_prev = req_valid2;
    endtask

    // monitor: compare what decode sees against the scoreboard head
    always @(negedge clk) begin
        logic [63:0] head;
        if (!rst) begin
            if (exp_q.size() > 0 && cyc != push_cyc) begin
                head = exp_q[0];
                check(out_valid == 1'b1, "out_valid_hold", 32'(out_valid), 32'h1);
                check(out_pc == head[63:32], "out_pc", out_pc, head[63:32]);
                check(out_instr == head[31:0], "out_instr", out_instr, head[31:0]);
                if (out_ready) begin
                    if (force_out_en) begin
                        check(out_pc == force_out_pc, "redir_out_pc", out_pc, force_out_pc);
                        force_out_en = 0;
                    end
                    void'(exp_q.pop_front());
                    delivered++;
                end else if (redirect_valid) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                check(out_valid == 1'b0, "out_valid_idle", 32'(out_valid), 32'h0);
            end
        end
    end

    initial begin
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        req_ready2 = 1; rsp_valid2 = 0; rsp_data2 = 0;
        redirect2 = 0; redirect_pc2 = 0; out_ready2 = 1;

        // sequential fetch, single-cycle memory
        step(1); step(1);
        repeat (20) step(0);

        // decode stall while holding an instruction
        p_ordy = 0;
        repeat (12) step(0);
        p_ordy = 100;
        repeat (6) step(0);

        // redirect while a request is in flight
        lat_min = 3; lat_max = 3;
        redir_in_wait = 1;
        for (int i = 0; i < 40 && redir_in_wait; i++) step(0);
        check(!redir_in_wait, "redir_wait_fired", 32'(redir_in_wait), 32'h0);
        repeat (12) step(0);
        check(!force_addr_en && !force_out_en, "redir_wait_done",
              32'({force_addr_en, force_out_en}), 32'h0);

        // redirect coinciding with a ready memory in REQ
        lat_min = 1; lat_max = 1;
        redir_in_req = 1;
        for (int i = 0; i < 40 && redir_in_req; i++) step(0);
        check(!redir_in_req, "redir_req_fired", 32'(redir_in_req), 32'h0);
        repeat (8) step(0);
        check(!force_addr_en, "redir_req_done", 32'(force_addr_en), 32'h0);

        // reset pulse while waiting, response arrives after release
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 40 && !model_wait; i++) step(0);
        check(model_wait, "rst_wait_reached", 32'(model_wait), 32'h1);
        step(0);
        step(1); step(1);
        repeat (15) step(0);
        check(hs_idx >= 1, "refetch_after_rst", 32'(hs_idx), 32'h1);

        // randomised traffic
        p_rdy = 70; p_ordy = 60; p_redir = 8; p_spur = 20;
        lat_min = 1; lat_max = 3;
        repeat (1500) step(0);

        // drain
        p_redir = 0; p_spur = 0; p_rdy = 100; p_ordy = 100;
        repeat (20) step(0);
        p_rdy = 0;
        repeat (10) step(0);
        check(exp_q.size() == 0, "drain_empty", 32'(exp_q.size()), 32'h0);
        check(!model_wait, "drain_idle", 32'(model_wait), 32'h0);
        check(delivered > 50, "delivered_count", 32'(delivered), 32'd51);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath width of addresses and instructions.
REQ-002 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 imem_req_valid  output  1  SHALL indicate that a fetch request is presented.
REQ-006 imem_req_ready  input  1  SHALL indicate that memory accepts the request this cycle.
REQ-007 imem_addr  output  XLEN  SHALL carry the fetch address, word-aligned.
REQ-008 imem_rsp_valid  input  1  SHALL indicate that instruction data is returned this cycle.
REQ-009 imem_rsp_data  input  XLEN  SHALL carry the returned instruction word.
REQ-010 redirect_valid  input  1  SHALL request a control-flow redirect (branch, jump or trap).
REQ-011 redirect_pc  input  XLEN  SHALL carry the redirect target.
REQ-012 out_valid  output  1  SHALL indicate that a fetched instruction is offered to decode.
REQ-013 out_ready  input  1  SHALL indicate that decode accepts the instruction this cycle.
REQ-014 out_pc  output  XLEN  SHALL carry the PC of the offered instruction.
REQ-015 out_instr  output  XLEN  SHALL carry the offered instruction word.

Function
REQ-016 The block SHALL implement an FSM with states REQ, WAIT and HOLD, and SHALL keep at most one memory request outstanding.
REQ-017 REQ state: imem_req_valid SHALL equal !redirect_valid, and imem_addr SHALL equal pc; on a handshake, fetch_pc <= pc, pc <= pc+4, and the FSM goes to WAIT.
REQ-018 pc+4 SHALL wrap modulo 2^XLEN (0xFFFFFFFC+4 -> 0x00000000).
REQ-019 WAIT state: on imem_rsp_valid with kill=0, out_pc <= fetch_pc, out_instr <= imem_rsp_data, out_valid <= 1, and the FSM goes to HOLD; with kill=1, the response SHALL be discarded, kill <= 0, and the FSM goes to REQ.
REQ-020 HOLD state: out_valid, out_pc and out_instr SHALL remain stable until out_valid && out_ready; on that handshake, out_valid <= 0 and the FSM goes to REQ.
REQ-021 Redirect SHALL take priority over sequential update in every state: pc <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-022 Redirect in REQ SHALL suppress the request that cycle, and the FSM SHALL stay in REQ.
REQ-023 Redirect in WAIT SHALL set kill <= 1; a redirect coinciding with imem_rsp_valid SHALL discard that response and go to REQ.
REQ-024 Redirect in HOLD SHALL set out_valid <= 0 and go to REQ; a coincident out_ready handshake SHALL still count as transferred.
REQ-025 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-026 Minimum latency SHALL be: request handshake at cycle N, response at N+1 or later, out_valid asserted the cycle after the response.

Reset
REQ-027 Reset SHALL force pc = RESET_PC, state = REQ, kill = 0, out_valid = 0, out_pc = 0, out_instr = 0, and fetch_pc = 0.
REQ-028 Reset asserted mid-transaction SHALL abandon any outstanding request; a response arriving after reset release in REQ SHALL be ignored per REQ-025.
REQ-029 imem_req_valid SHALL be asserted in the first cycle after reset release with imem_addr = RESET_PC.

Structure
REQ-030 The FSM state encoding and the instruction-width constant SHALL reside in the shared core package.
REQ-031 The pc register SHALL be one instance of the team's generic register sub-module syn_reg (WIDTH=XLEN, INITIAL=RESET_PC), with write enable = request handshake || redirect_valid.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory -> imem_addr sequence 0x0, 0x4, 0x8, with out_pc matching and each word delivered exactly once.
REQ-033 out_ready=0 for 5 cycles in HOLD -> out_pc and out_instr stable, no new imem request until the handshake.
REQ-034 Redirect to 0x103 while in WAIT -> in-flight response discarded, next imem_addr = 0x100, next out_pc = 0x100.
REQ-035 RESET_PC=0xFFFFFFFC -> second fetch address = 0x00000000.
REQ-036 Redirect in the same cycle as imem_req_ready in REQ -> imem_req_valid=0, next request to the redirect target.
REQ-037 rst pulse while in WAIT, followed by a late imem_rsp_valid -> response ignored, out_valid stays 0, refetch from RESET_PC.
